// File: rtl/crc_serial_engine_if.sv
// Serial CRC engine handshake bundle: control, serial input, serial output and status.
// The master modport drives the engine; the slave modport is the engine itself.
interface crc_serial_engine_if #(
    parameter int unsigned CRC_W = 5,
    parameter int unsigned LEN_W = 14
) ();
    logic             start;
    logic             mode;
    logic [LEN_W-1:0] len;
    logic             s_in;
    logic             s_valid;
    logic             s_out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic             crc_ok;
    logic [CRC_W-1:0] crc_val;
    logic             ack;

    modport master (
        output start, mode, len, s_in, s_valid, out_ready, ack,
        input  s_out, out_valid, busy, done, crc_ok, crc_val
    );

    modport slave (
        input  start, mode, len, s_in, s_valid, out_ready, ack,
        output s_out, out_valid, busy, done, crc_ok, crc_val
    );
endinterface

// File: rtl/crc_serial_engine.sv
// Serial CRC generator/checker, LSB-first payload; GEN appends complemented CRC MSB first,
// CHK absorbs the received CRC and compares the register against the good-packet residue.
module crc_serial_engine #(
    parameter int unsigned      CRC_W   = 5,
    parameter logic [CRC_W-1:0] POLY    = 5'h05,
    parameter logic [CRC_W-1:0] INIT    = '1,
    parameter logic [CRC_W-1:0] RESIDUE = 5'h0C,
    parameter int unsigned      LEN_W   = 14
) (
    input logic                clk,
    input logic                rst,
    crc_serial_engine_if.slave bus
);
    localparam int unsigned IdxW = (CRC_W > 1) ? $clog2(CRC_W) : 1;

    typedef enum logic [2:0] {StIdle, StPayload, StAppend, StRxcrc, StDone} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             mode_q, mode_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic             crc_ok_q, crc_ok_d;
    logic [CRC_W-1:0] crc_upd;
    logic             fb;
    logic [IdxW-1:0]  bit_idx;

    always_comb begin
        fb      = crc_q[CRC_W-1] ^ bus.s_in;
        crc_upd = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        // During APPEND cnt never exceeds CRC_W-1, so the low bits suffice as an index.
        bit_idx = IdxW'(CRC_W - 1) - cnt_q[IdxW-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        mode_d   = mode_q;
        crc_d    = crc_q;
        crc_ok_d = crc_ok_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    crc_d    = INIT;
                    cnt_d    = '0;
                    mode_d   = bus.mode;
                    len_d    = bus.len;
                    crc_ok_d = 1'b0;
                    if (bus.len != '0) state_d = StPayload;
                    else               state_d = bus.mode ? StRxcrc : StAppend;
                end
            end
            StPayload: begin
                if (bus.s_valid) begin
                    crc_d = crc_upd;
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        cnt_d   = '0;
                        state_d = mode_q ? StRxcrc : StAppend;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            StAppend: begin
                if (bus.out_ready) begin
                    if (cnt_q == LEN_W'(CRC_W - 1)) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            StRxcrc: begin
                if (bus.s_valid) begin
                    crc_d = crc_upd;
                    if (cnt_q == LEN_W'(CRC_W - 1)) begin
                        cnt_d    = '0;
                        crc_ok_d = (crc_upd == RESIDUE);
                        state_d  = StDone;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            StDone: begin
                if (bus.ack) begin
                    crc_ok_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            len_q    <= '0;
            mode_q   <= 1'b0;
            crc_q    <= INIT;
            crc_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            mode_q   <= mode_d;
            crc_q    <= crc_d;
            crc_ok_q <= crc_ok_d;
        end
    end

    assign bus.out_valid = (state_q == StAppend);
    assign bus.s_out     = (state_q == StAppend) ? ~crc_q[bit_idx] : 1'b0;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.crc_ok    = crc_ok_q;
    assign bus.crc_val   = crc_q;
endmodule

// File: tb/tb_crc_serial_engine.sv
// Directed bench for crc_serial_engine: CRC5 token GEN/CHK paths, a CRC16 zero-length check,
// reset mid-packet, stalls on both sides, and length boundaries.
module tb_crc_serial_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    crc_serial_engine_if #(.CRC_W(5),  .LEN_W(14)) if5  ();
    crc_serial_engine_if #(.CRC_W(16), .LEN_W(14)) if16 ();

    crc_serial_engine #(
        .CRC_W(5), .POLY(5'h05), .INIT(5'h1F), .RESIDUE(5'h0C), .LEN_W(14)
    ) u_crc5 (.clk(clk), .rst(rst), .bus(if5));

    crc_serial_engine #(
        .CRC_W(16), .POLY(16'h8005), .INIT(16'hFFFF), .RESIDUE(16'h800D), .LEN_W(14)
    ) u_crc16 (.clk(clk), .rst(rst), .bus(if16));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_op5(input logic m, input logic [13:0] l);
        if5.start = 1'b1;
        if5.mode  = m;
        if5.len   = l;
        @(negedge clk);
        if5.start = 1'b0;
    endtask

    // bits[i] is the i-th bit on the wire; toggle inserts an idle cycle before every bit.
    task automatic send5(input logic [31:0] bits, input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            if (toggle) begin
                if5.s_valid = 1'b0;
                if5.s_in    = ~bits[i];
                @(negedge clk);
            end
            if5.s_in    = bits[i];
            if5.s_valid = 1'b1;
            @(negedge clk);
        end
        if5.s_valid = 1'b0;
        if5.s_in    = 1'b0;
    endtask

    // field[k] is the k-th appended bit; hold_n stall cycles are inserted before handshake hold_at.
    task automatic collect5(input int hold_at, input int hold_n,
                            output logic [4:0] field, output int serr, output int nhs);
        int   cyc  = 0;
        int   held = 0;
        logic hb   = 1'b0;
        field = '0;
        serr  = 0;
        nhs   = 0;
        while (nhs < 5 && cyc < 60) begin
            if (nhs == hold_at && held < hold_n) begin
                if5.out_ready = 1'b0;
                if (held == 0) hb = if5.s_out;
                else if (if5.s_out !== hb) serr++;
                held++;
            end else begin
                if5.out_ready = 1'b1;
                if (if5.out_valid === 1'b1) begin
                    if (held > 0 && nhs == hold_at && if5.s_out !== hb) serr++;
                    field[nhs] = if5.s_out;
                    nhs++;
                end
            end
            cyc++;
            @(negedge clk);
        end
        if5.out_ready = 1'b0;
    endtask

    task automatic ack5();
        if5.ack = 1'b1;
        @(negedge clk);
        if5.ack = 1'b0;
    endtask

    initial begin
        logic [4:0] field;
        int         serr;
        int         nhs;

        rst = 1'b1;
        {if5.start, if5.mode, if5.s_in, if5.s_valid, if5.out_ready, if5.ack} = '0;
        {if16.start, if16.mode, if16.s_in, if16.s_valid, if16.out_ready, if16.ack} = '0;
        if5.len  = '0;
        if16.len = '0;
        repeat (3) @(negedge clk);

        check("rst_busy", if5.busy, 1'b0);
        check("rst_done", if5.done, 1'b0);
        check("rst_out_valid", if5.out_valid, 1'b0);
        check("rst_s_out", if5.s_out, 1'b0);
        check("rst_crc_ok", if5.crc_ok, 1'b0);
        check("rst_crc_val5", if5.crc_val, 5'h1F);
        check("rst_crc_val16", if16.crc_val, 16'hFFFF);
        rst = 1'b0;
        @(negedge clk);

        // GEN, addr 0 / endp 0
        start_op5(1'b0, 14'd11);
        check("c1_busy", if5.busy, 1'b1);
        send5(32'h0, 11, 1'b0);
        check("c1_latency", if5.out_valid, 1'b1);
        check("c1_crc_reg", if5.crc_val, 5'h17);
        collect5(-1, 0, field, serr, nhs);
        check("c1_field", field, 5'h02);
        check("c1_handshakes", nhs, 5);
        check("c1_done", if5.done, 1'b1);
        check("c1_out_valid_off", if5.out_valid, 1'b0);
        check("c1_crc_ok_gen", if5.crc_ok, 1'b0);
        check("c1_crc_held", if5.crc_val, 5'h17);
        ack5();
        check("c1_ack_busy", if5.busy, 1'b0);
        check("c1_ack_done", if5.done, 1'b0);

        // GEN, addr 0x70 / endp 4 (payload word 0x270), stalled mid-append
        start_op5(1'b0, 14'd11);
        send5(32'h0000_0270, 11, 1'b0);
        check("c2_crc_reg", if5.crc_val, 5'h11);
        collect5(2, 3, field, serr, nhs);
        check("c2_field", field, 5'h0E);
        check("c2_handshakes", nhs, 5);
        check("c2_stall_stable", serr, 0);
        check("c2_done", if5.done, 1'b1);
        ack5();

        // CHK with the case-1 payload and its CRC field
        start_op5(1'b1, 14'd11);
        send5(32'h0, 11, 1'b0);
        check("c3_rx_no_out", if5.out_valid, 1'b0);
        send5(32'h02, 5, 1'b0);
        check("c3_done", if5.done, 1'b1);
        check("c3_residue", if5.crc_val, 5'h0C);
        check("c3_crc_ok", if5.crc_ok, 1'b1);
        ack5();
        check("c3_crc_ok_drop", if5.crc_ok, 1'b0);
        check("c3_done_drop", if5.done, 1'b0);

        start_op5(1'b1, 14'd11);
        send5(32'h1, 11, 1'b0);
        send5(32'h02, 5, 1'b0);
        check("c3_flip_done", if5.done, 1'b1);
        check("c3_flip_crc_ok", if5.crc_ok, 1'b0);
        ack5();

        // CRC16 CHK, zero-length DATA packet
        if16.start = 1'b1;
        if16.mode  = 1'b1;
        if16.len   = '0;
        @(negedge clk);
        if16.start = 1'b0;
        check("c4_busy", if16.busy, 1'b1);
        if16.s_in    = 1'b0;
        if16.s_valid = 1'b1;
        repeat (16) @(negedge clk);
        if16.s_valid = 1'b0;
        check("c4_done", if16.done, 1'b1);
        check("c4_residue", if16.crc_val, 16'h800D);
        check("c4_crc_ok", if16.crc_ok, 1'b1);
        if16.ack = 1'b1;
        @(negedge clk);
        if16.ack = 1'b0;
        check("c4_idle", if16.busy, 1'b0);

        // Reset mid-payload, then a clean rerun
        start_op5(1'b0, 14'd11);
        send5(32'h0, 6, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("c5_busy", if5.busy, 1'b0);
        check("c5_crc_init", if5.crc_val, 5'h1F);
        check("c5_out_valid", if5.out_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        start_op5(1'b0, 14'd11);
        send5(32'h0, 11, 1'b0);
        collect5(-1, 0, field, serr, nhs);
        check("c5_field", field, 5'h02);
        check("c5_done", if5.done, 1'b1);
        ack5();

        // Gapped input and a start pulse with different mode/len while busy
        start_op5(1'b0, 14'd11);
        if5.start = 1'b1;
        if5.mode  = 1'b1;
        if5.len   = 14'd3;
        @(negedge clk);
        if5.start = 1'b0;
        send5(32'h0000_0270, 11, 1'b1);
        check("c6_out_valid", if5.out_valid, 1'b1);
        check("c6_crc_reg", if5.crc_val, 5'h11);
        collect5(-1, 0, field, serr, nhs);
        check("c6_field", field, 5'h0E);
        ack5();

        // len=0 GEN appends ~INIT directly; then ack and start together in DONE
        start_op5(1'b0, 14'd0);
        check("len0_out_valid", if5.out_valid, 1'b1);
        collect5(-1, 0, field, serr, nhs);
        check("len0_field", field, 5'h00);
        check("len0_crc_val", if5.crc_val, 5'h1F);
        check("len0_done", if5.done, 1'b1);
        if5.ack   = 1'b1;
        if5.start = 1'b1;
        if5.mode  = 1'b0;
        if5.len   = 14'd0;
        @(negedge clk);
        if5.ack   = 1'b0;
        if5.start = 1'b0;
        check("ack_start_idle", if5.busy, 1'b0);
        @(negedge clk);
        check("ack_start_stays_idle", if5.busy, 1'b0);

        // Maximum length must not wrap the counter
        start_op5(1'b0, 14'h3FFF);
        if5.s_in    = 1'b0;
        if5.s_valid = 1'b1;
        repeat (16382) @(negedge clk);
        check("maxlen_not_yet", if5.out_valid, 1'b0);
        @(negedge clk);
        if5.s_valid = 1'b0;
        check("maxlen_append", if5.out_valid, 1'b1);
        collect5(-1, 0, field, serr, nhs);
        check("maxlen_handshakes", nhs, 5);
        check("maxlen_done", if5.done, 1'b1);
        ack5();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
